bus_manager: RTL
================

BUS_MANAGER -- requirements
Module: bus_manager

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles BUSY waits for wb_ack_i before abort.
REQ-002 SHALL have ports, clock and reset first: clk in 1 system clock; nrst in 1 reset, asynchronous, active-low.
REQ-003 SHALL have mem_read in 1 (read request from memory controller) and mem_write in 1 (write request).
REQ-004 SHALL have mem_address in 32 (byte address), mem_wdata in 32 (write data) and mem_sel in 4 (byte lane enables).
REQ-005 SHALL have bus_full out 1 (busy, requests ignored), mem_rdata out 32 (read data), mem_done out 1 (completion pulse) and mem_err out 1 (timeout pulse).
REQ-006 SHALL have wb_cyc out 1, wb_stb out 1, wb_we out 1, wb_sel out 4, wb_adr out 32 and wb_dat_o out 32 (bus master outputs).
REQ-007 SHALL have wb_dat_i in 32 (bus read data) and wb_ack_i in 1 (bus acknowledge).

Function
REQ-008 SHALL implement states IDLE, BUSY, DONE and ERROR.
REQ-009 IDLE SHALL hold bus_full=0, wb_cyc=0 and wb_stb=0.
REQ-010 IDLE with mem_read or mem_write high at a clock edge SHALL latch address, wdata, sel and op, then enter BUSY.
REQ-011 If mem_read and mem_write are both high, read SHALL win, with wb_we=0.
REQ-012 BUSY SHALL drive wb_cyc=1, wb_stb=1, wb_we=op, and wb_adr, wb_dat_o and wb_sel from the latched values, stable for the whole state.
REQ-013 In BUSY, wb_dat_o SHALL be 0 for reads.
REQ-014 bus_full SHALL be 1 in BUSY, DONE and ERROR.
REQ-015 mem_read and mem_write SHALL be ignored whenever bus_full=1.
REQ-016 wb_ack_i in BUSY SHALL end the transfer: next state DONE; wb_cyc and wb_stb low from the next cycle.
REQ-017 On a read ack, mem_rdata SHALL register wb_dat_i.
REQ-018 On a write ack, mem_rdata SHALL be unchanged.
REQ-019 DONE SHALL last exactly one cycle, with mem_done=1 and mem_err=0, then return to IDLE.
REQ-020 Latency: request sampled at edge 0 -> wb_stb high cycle 1.
REQ-021 Latency: ack sampled at edge k -> mem_done high cycle k+1 -> bus_full=0 cycle k+2.
REQ-022 A 6-bit timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 with no ack, the block SHALL go to ERROR and drop wb_cyc and wb_stb.
REQ-024 If wb_ack_i arrives in the same cycle the timeout fires, the ack SHALL win and the block SHALL go to DONE.
REQ-025 ERROR SHALL last one cycle with mem_done=1, mem_err=1 and mem_rdata=0, then return to IDLE.
REQ-026 wb_ack_i outside BUSY SHALL be ignored.
REQ-027 mem_done and mem_err SHALL never be high for more than one consecutive cycle.
REQ-028 Unreachable state encodings SHALL recover to IDLE.

Reset
REQ-029 nrst low SHALL immediately force state IDLE, all wb_* outputs to 0, mem_rdata=0, mem_done=0, mem_err=0, bus_full=0 and timeout counter=0.
REQ-030 Reset asserted mid-BUSY SHALL abort the transfer with no mem_done pulse.
REQ-031 The first request SHALL be accepted at the first edge after nrst deasserts.

Structure
REQ-032 A shared package SHALL hold bus_state_t (IDLE, BUSY, DONE, ERROR) and the default timeout constant.
REQ-033 The timeout counter SHALL be a sub-module, bus_timeout_counter, with inputs clear, enable and limit and output expired.
REQ-034 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from wb_ack_i to mem_done.

Verification
REQ-035 Read: mem_read=1, addr 0x0000_0040, ack on 3rd BUSY cycle with wb_dat_i 0xDEAD_BEEF -> wb_we=0, mem_rdata=0xDEAD_BEEF, one-cycle mem_done, bus_full low 2 cycles after ack.
REQ-036 Write: mem_write=1, addr 0x0000_0080, wdata 0x1234_5678, sel 0xF, ack after 1 cycle -> wb_we=1, wb_dat_o=0x1234_5678, mem_done pulse, mem_rdata unchanged.
REQ-037 Timeout: read with no ack, TIMEOUT_CYCLES=16 -> wb_stb high exactly 16 cycles, then mem_err=1, mem_done=1, mem_rdata=0 for one cycle, then IDLE.
REQ-038 Contention: mem_read=mem_write=1, then a new mem_write while bus_full=1 -> read performed, second request ignored, no extra wb_stb.
REQ-039 Reset: nrst low on 2nd BUSY cycle -> wb_cyc, wb_stb and bus_full go 0 immediately with no mem_done; request after release completes normally.
REQ-040 Ack-at-timeout: ack in cycle 16 of BUSY -> DONE with mem_err=0 and data captured.

Source files
------------

// File: rtl/bus_manager_pkg.sv
// ---------------------------------------------------------------------------
// Module  : bus_manager_pkg
// Brief   : Shared state type and timeout constants for the bus manager.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package bus_manager_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } bus_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int TIMER_W                = 6;

endpackage

`default_nettype wire

// File: rtl/bus_timeout_counter.sv
// ---------------------------------------------------------------------------
// Module  : bus_timeout_counter
// Brief   : Counts un-acknowledged bus cycles and flags when the limit is hit.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bus_timeout_counter
    import bus_manager_pkg::*;
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    localparam logic [TIMER_W-1:0] c_one = TIMER_W'(1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count holds the number of completed wait cycles, so limit-1 marks the last one.
    assign expired = enable && (count_q == (limit - c_one));

endmodule

`default_nettype wire

// File: rtl/bus_manager.sv
// ---------------------------------------------------------------------------
// Module  : bus_manager
// Brief   : Single-transfer Wishbone master bridging memory-controller requests.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bus_manager
    import bus_manager_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic        bus_full,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam logic [TIMER_W-1:0] c_limit = TIMER_W'(TIMEOUT_CYCLES);

    bus_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_busy;
    logic        w_expired;

    assign w_busy = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = BUSY;
                    we_d    = !mem_read;
                    adr_d   = mem_address;
                    wdat_d  = mem_wdata;
                    sel_d   = mem_sel;
                end
            end
            BUSY: begin
                // Ack is checked first so a late ack beats the timeout.
                if (wb_ack_i) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = wb_dat_i;
                    end
                end else if (w_expired) begin
                    state_d = ERROR;
                    rdata_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

    bus_timeout_counter u_timeout (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (!w_busy),
        .enable  (w_busy && !wb_ack_i),
        .limit   (c_limit),
        .expired (w_expired)
    );

    assign bus_full  = (state_q != IDLE);
    assign mem_done  = (state_q == DONE) || (state_q == ERROR);
    assign mem_err   = (state_q == ERROR);
    assign mem_rdata = rdata_q;

    assign wb_cyc    = w_busy;
    assign wb_stb    = w_busy;
    assign wb_we     = w_busy && we_q;
    assign wb_sel    = w_busy ? sel_q : 4'h0;
    assign wb_adr    = w_busy ? adr_q : 32'h0;
    assign wb_dat_o  = (w_busy && we_q) ? wdat_q : 32'h0;

endmodule

`default_nettype wire
